// File: rtl/sha256_pkg.sv
// sha256_pkg: shared SHA-256 link constants and the FSM state encoding
//   DATA_WIDTH  word width
//   BLK_WORDS   words per 512-bit block
//   IDX_W       width of the index sent with each word
//   PTR_W       width of the internal word pointers
//   state_t     s_IDLE / s_SEND / s_WAIT (2'b11 unused and recovered to s_IDLE)
package sha256_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int BLK_WORDS = 16;
  localparam int IDX_W = 5;
  localparam int PTR_W = $clog2(BLK_WORDS);
  typedef enum logic [1:0] {
    s_IDLE = 2'b00,
    s_SEND = 2'b01,
    s_WAIT = 2'b10
  } state_t;
endpackage

// File: rtl/sha_me_tx_if.sv
// sha_me_tx_if: word link between the input path, sha_me_tx and the expansion block
//   s_valid_in/s_data_in/s_ready_out   upstream word handshake
//   start_out/Rx_core_count_out/data_out  indexed word stream toward expansion
//   me_dv_in                           expansion done pulse
//   slave modport is the transmitter side, master the surrounding side
interface sha_me_tx_if #(parameter int DATA_WIDTH = sha256_pkg::DATA_WIDTH);
  logic s_valid_in;
  logic [DATA_WIDTH-1:0] s_data_in;
  logic s_ready_out;
  logic start_out;
  logic [sha256_pkg::IDX_W-1:0] Rx_core_count_out;
  logic [DATA_WIDTH-1:0] data_out;
  logic me_dv_in;
  modport slave(input s_valid_in, s_data_in, me_dv_in, output s_ready_out, start_out, Rx_core_count_out, data_out);
  modport master(output s_valid_in, s_data_in, me_dv_in, input s_ready_out, start_out, Rx_core_count_out, data_out);
endinterface

// File: rtl/sha_pingpong_buf.sv
// sha_pingpong_buf: two-bank 16-word block buffer with full flags and write pointer
//   wr_en/wr_data/ready  write handshake (write happens on wr_en && ready)
//   clr                  releases bank rd_bank after it has been acknowledged
//   rd_bank/rd_idx       combinational read port, rd_data
//   full                 per-bank full flags
module sha_pingpong_buf
  import sha256_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  ready,
  input  logic                  clr,
  input  logic                  rd_bank,
  input  logic [PTR_W-1:0]      rd_idx,
  output logic [1:0]            full,
  output logic [DATA_WIDTH-1:0] rd_data
);
  logic [DATA_WIDTH-1:0] bank [2][BLK_WORDS];
  logic wr_bank;
  logic [PTR_W-1:0] wr_idx;
  logic we, last;
  assign ready = !full[wr_bank];
  assign we = wr_en && ready;
  assign last = we && wr_idx == PTR_W'(BLK_WORDS - 1);
  assign rd_data = bank[rd_bank][rd_idx];
  always_ff @(posedge clk)
    if (we) bank[wr_bank][wr_idx] <= wr_data;
  // set and clear always address different banks, so both apply in one cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      full <= '0;
      wr_bank <= 1'b0;
      wr_idx <= '0;
    end else begin
      full <= (full | ({1'b0, last} << wr_bank)) & ~({1'b0, clr} << rd_bank);
      wr_bank <= wr_bank ^ last;
      wr_idx <= wr_idx + PTR_W'(we);
    end
endmodule

// File: rtl/sha_me_tx.sv
// sha_me_tx: streams buffered 512-bit blocks to message expansion as 16 indexed words
//   clk, rst_n    clock and asynchronous active-low reset
//   bus           sha_me_tx_if.slave: upstream handshake, word stream, done pulse
//   o_FSM_state   current state for debug
//   o_blk_count   acknowledged blocks, wraps at 2^16
module sha_me_tx
  import sha256_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  sha_me_tx_if.slave  bus,
  output logic [1:0]  o_FSM_state,
  output logic [15:0] o_blk_count
);
  state_t state, state_n;
  logic rd_bank, ack;
  logic [PTR_W-1:0] tx_idx, idx_n;
  logic [1:0] full;
  logic [DATA_WIDTH-1:0] rd_data, data_q;
  sha_pingpong_buf u_buf (
    .clk(clk),
    .rst_n(rst_n),
    .wr_en(bus.s_valid_in),
    .wr_data(bus.s_data_in),
    .ready(bus.s_ready_out),
    .clr(ack),
    .rd_bank(rd_bank),
    .rd_idx(idx_n),
    .full(full),
    .rd_data(rd_data)
  );
  // the read address is the next cycle's index so data_q lines up with tx_idx
  assign idx_n = state == s_SEND ? tx_idx + PTR_W'(1) : '0;
  always_comb begin
    state_n = state;
    ack = 1'b0;
    case (state)
      s_IDLE: state_n = full[rd_bank] ? s_SEND : s_IDLE;
      s_SEND: state_n = tx_idx == PTR_W'(BLK_WORDS - 1) ? s_WAIT : s_SEND;
      s_WAIT: begin
        ack = bus.me_dv_in;
        state_n = bus.me_dv_in ? s_IDLE : s_WAIT;
      end
      default: state_n = s_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= s_IDLE;
      tx_idx <= '0;
      rd_bank <= 1'b0;
      o_blk_count <= '0;
      data_q <= '0;
    end else begin
      state <= state_n;
      tx_idx <= idx_n;
      rd_bank <= rd_bank ^ ack;
      o_blk_count <= o_blk_count + 16'(ack);
      data_q <= state_n == s_SEND ? rd_data : '0;
    end
  assign bus.start_out = state == s_SEND;
  assign bus.Rx_core_count_out = bus.start_out ? IDX_W'(tx_idx) : '0;
  assign bus.data_out = data_q;
  assign o_FSM_state = state;
endmodule

// File: tb/tb_sha_me_tx.sv
// tb_sha_me_tx: directed self-checking bench for sha_me_tx
module tb_sha_me_tx;
  import sha256_pkg::*;
  typedef struct {
    logic [31:0] base;
    bit gap;
    int dly;
  } vec_t;
  typedef struct {
    logic [4:0] idx;
    logic [31:0] data;
    int cyc;
  } rx_t;
  logic clk = 0;
  logic rst_n = 0;
  logic [1:0] fsm;
  logic [15:0] blk;
  int cyc = 0;
  int total = 0, passed = 0, stalls = 0;
  logic [15:0] eb = 0;
  rx_t rx_q[$];
  logic [31:0] exp_q[$];
  vec_t tbl[4];
  sha_me_tx_if #(.DATA_WIDTH(32)) bus();
  sha_me_tx dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .o_FSM_state(fsm),
    .o_blk_count(blk)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.start_out) rx_q.push_back('{bus.Rx_core_count_out, bus.data_out, cyc});

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    int n = 0;
    bus.s_valid_in = 1;
    bus.s_data_in = w;
    while (!bus.s_ready_out && n < 200) begin
      step();
      n++;
      stalls++;
    end
    if (n >= 200) chk("push_timeout", 0, 1);
    else exp_q.push_back(w);
    step();
    bus.s_valid_in = 0;
  endtask

  task automatic ack();
    bus.me_dv_in = 1;
    step();
    bus.me_dv_in = 0;
  endtask

  task automatic check_block(input string nm, output int first);
    int n = 0;
    rx_t r;
    logic [31:0] e;
    first = -1;
    while (rx_q.size() < 16 && n < 300) begin
      step();
      n++;
    end
    if (rx_q.size() < 16) begin
      chk({nm, "_timeout"}, 64'(rx_q.size()), 16);
      return;
    end
    first = rx_q[0].cyc;
    for (int i = 0; i < 16; i++) begin
      r = rx_q.pop_front();
      e = exp_q.size() > 0 ? exp_q.pop_front() : 32'hxxxxxxxx;
      chk({nm, "_idx"}, r.idx, 64'(i));
      chk({nm, "_data"}, r.data, e);
      chk({nm, "_cyc"}, 64'(r.cyc), 64'(first + i));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int first, c0, n;
    tbl[0] = '{32'h00000000, 1'b0, 40};
    tbl[1] = '{32'hA0000000, 1'b1, 20};
    tbl[2] = '{32'hB0000000, 1'b1, 20};
    tbl[3] = '{32'hC0000000, 1'b1, 20};
    bus.s_valid_in = 0;
    bus.s_data_in = 0;
    bus.me_dv_in = 0;
    repeat (3) step();
    chk("rst_state", fsm, s_IDLE);
    chk("rst_start", bus.start_out, 0);
    chk("rst_idx", bus.Rx_core_count_out, 0);
    chk("rst_data", bus.data_out, 0);
    chk("rst_blk", blk, 0);
    rst_n = 1;
    step();
    chk("rst_ready", bus.s_ready_out, 1);
    // single block and gapped blocks
    foreach (tbl[k]) begin
      stalls = 0;
      for (int i = 0; i < 16; i++) begin
        if (tbl[k].gap && $urandom_range(0, 1) == 1) step();
        push(tbl[k].base + 32'(i));
      end
      check_block("blk", first);
      chk("blk_wait", fsm, s_WAIT);
      chk("blk_nostall", 64'(stalls), 0);
      repeat (tbl[k].dly) step();
      ack();
      eb++;
      chk("blk_idle", fsm, s_IDLE);
      chk("blk_count", blk, eb);
    end
    // ping-pong fill with done held off
    stalls = 0;
    for (int i = 0; i < 32; i++) push(32'(i));
    chk("pp_nostall", 64'(stalls), 0);
    check_block("pp1", first);
    chk("pp_wait", fsm, s_WAIT);
    chk("pp_full", bus.s_ready_out, 0);
    bus.s_valid_in = 1;
    bus.s_data_in = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      chk("pp_33rd_ready", bus.s_ready_out, 0);
      step();
    end
    bus.s_valid_in = 0;
    chk("pp_hold", fsm, s_WAIT);
    c0 = cyc;
    ack();
    eb++;
    chk("rel_ready", bus.s_ready_out, 1);
    chk("rel_idle", fsm, s_IDLE);
    check_block("pp2", first);
    chk("rel_latency", 64'(first), 64'(c0 + 2));
    ack();
    eb++;
    chk("rel_count", blk, eb);
    // spurious done pulses
    ack();
    chk("spur_idle", fsm, s_IDLE);
    chk("spur_idle_blk", blk, eb);
    chk("spur_idle_ready", bus.s_ready_out, 1);
    for (int i = 0; i < 16; i++) push(32'h30000000 + 32'(i));
    n = 0;
    while (rx_q.size() < 5 && n < 100) begin
      step();
      n++;
    end
    ack();
    chk("spur_send", fsm, s_SEND);
    chk("spur_send_blk", blk, eb);
    check_block("spur", first);
    chk("spur_wait", fsm, s_WAIT);
    ack();
    eb++;
    chk("spur_count", blk, eb);
    // reset in the middle of a send
    for (int i = 0; i < 16; i++) push(32'h50000000 + 32'(i));
    n = 0;
    while (!(bus.start_out && bus.Rx_core_count_out == 5'd7) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("mid_reached", bus.Rx_core_count_out, 7);
    rst_n = 0;
    #1;
    chk("mid_start", bus.start_out, 0);
    chk("mid_idx", bus.Rx_core_count_out, 0);
    chk("mid_data", bus.data_out, 0);
    chk("mid_state", fsm, s_IDLE);
    chk("mid_blk", blk, 0);
    rx_q.delete();
    exp_q.delete();
    eb = 0;
    repeat (2) step();
    rst_n = 1;
    repeat (20) step();
    chk("mid_noresend", 64'(rx_q.size()), 0);
    for (int i = 0; i < 16; i++) push(32'h60000000 + 32'(i));
    check_block("fresh", first);
    ack();
    eb++;
    chk("fresh_count", blk, eb);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
